jtkcpu_idx_seq: RTL
===================

Name: jtkcpu_idx_seq

Overview:
- Sequencer for the indexed-addressing datapath (jtkcpu_idx).
- Decodes the postbyte and fetches 8/16-bit offset bytes from the PC stream or extended/direct operands.
- Performs the optional indirect pointer fetch and the register pre-decrement/post-increment writeback.
- Sits between the main ucode engine, which pulses `start`, and jtkcpu_idx; drives the idx_* strobes and the 16-bit mdata word that jtkcpu_idx consumes.

Parameters:
- None.

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  clock
- cen  in  1  clock enable; all state advances only when cen=1
- start  in  1  begin an indexed sequence; sampled only in IDLE
- postbyte  in  8  addressing postbyte, latched at start
- din  in  8  byte read from the bus
- bus_ack  in  1  din valid for the current fetch
- idx_addr  in  16  current address produced by jtkcpu_idx
- fetch_pc  out  1  request a byte read at PC; PC increments on ack
- fetch_ea  out  1  request a byte read at idx_addr+ptr_ofs
- ptr_ofs  out  1  0=high byte, 1=low byte of the indirect pointer
- mdata  out  16  assembled operand to jtkcpu_idx
- reg_sel  out  3  0=X 1=Y 2=U 3=S 4=PC
- acc_sel  out  2  0=A 1=B 2=D
- idx_8, idx_16, idx_acc, idx_dp, idx_ld, data2addr  out  1 each  one-cycle strobes to jtkcpu_idx
- reg_wr  out  1  one-cycle strobe: write reg_sel with reg_wdata
- reg_wdata_dlt  out  16  signed delta to add to the register (two's complement)
- busy  out  1  high from start accepted until done
- done  out  1  one-cycle pulse; idx_addr holds the final EA

Behaviour:
- Reset: state=IDLE; all outputs 0, including mdata and the latched postbyte.
- Postbyte encoding:
  - bit7 = indirect
  - bits6:4 = reg_sel; values 5–7 map to X
  - bits3:0 = mode:
    - 0 no offset
    - 1 ofs8
    - 2 ofs16
    - 3 accA, 4 accB, 5 accD
    - 6 post-inc 1, 7 post-inc 2
    - 8 pre-dec 1, 9 pre-dec 2
    - A extended
    - B direct-page
    - C–F illegal
- States: IDLE, PRE, OF1, OF2, CALC, POST, IH, IL, ILD, DONE.
- IDLE:
  - On start&cen: latch postbyte, busy=1.
  - Go to PRE for modes 8/9; OF1 for modes 1, 2, A, B; otherwise CALC.
- PRE: reg_wr with delta -1 or -2, then CALC.
- OF1:
  - Hold fetch_pc until bus_ack.
  - Mode 1 or B: mdata={8'h00,din}, go to CALC.
  - Mode 2 or A: mdata[15:8]=din, go to OF2.
- OF2: hold fetch_pc until ack; mdata[7:0]=din; go to CALC.
- CALC: exactly one strobe for one cycle.
  - Mode 0/6/7/8/9: idx_ld.
  - Mode 1: idx_8.
  - Mode 2: idx_16.
  - Mode 3–5: idx_acc, with acc_sel = mode-3.
  - Mode A: data2addr.
  - Mode B: idx_dp.
  - Next: POST for modes 6/7; otherwise IH if indirect, else DONE.
- POST: reg_wr with delta +1/+2; then IH if indirect, else DONE.
- IH: fetch_ea with ptr_ofs=0 until ack; mdata[15:8]=din.
- IL: fetch_ea with ptr_ofs=1 until ack; mdata[7:0]=din.
- ILD: data2addr strobe; then DONE.
- DONE: done=1 for one cen cycle, busy=0, return to IDLE.
- Stalls: a missing bus_ack holds state; fetch_* stays high.
- start while busy is ignored.
- cen=0: outputs hold; strobes are gated by cen at the consumer.
- Latency with zero-wait bus, counted in cen cycles from start to done:
  - no-offset: 3
  - ofs8: 4
  - ofs16: 5
  - each of PRE, POST adds 1
  - indirect adds 3
- Register writeback uses the pre-offset register value. PC-relative pre-dec/post-inc is treated as no offset (no reg_wr).
- Reset mid-sequence returns to IDLE immediately, drops all requests and strobes, and leaves no partial reg_wr.

Optional Feature:
- Macro: JTKCPU_IDX_ILLEGAL_EN
- Defined:
  - adds output `illegal` (1 bit)
  - modes C–F pulse `illegal` with `done` after a no-offset CALC
- Not defined:
  - modes C–F behave exactly as mode 0
  - no `illegal` port

Test Plan:
- Postbyte 0x01 (X, ofs8), din=0x80, X=0x1000 → idx_8 strobe with mdata=0x0080; EA=0x0F80; done 4 cycles after start.
- Postbyte 0x12 (Y, ofs16), din 0x12 then 0x34 → two fetch_pc acks, idx_16 with mdata=0x1234, done at cycle 5.
- Postbyte 0x29 (U, pre-dec 2) → reg_wr delta 0xFFFE before idx_ld; no fetch.
- Postbyte 0x8A (extended indirect): operand 0x2000, mem[0x2000..1]=0xBE,0xEF → data2addr twice; final mdata=0xBEEF; fetch_ea ptr_ofs sequence 0 then 1.
- Postbyte 0x02 with bus_ack withheld 3 cycles on the first fetch → state holds, fetch_pc stays high, done delayed by exactly 3.
- Reset asserted during IH → busy, fetch_ea and done all 0 the next cycle; a new start is accepted normally.

Source files
------------

// File: rtl/jtkcpu_idx_seq.sv
// Indexed-addressing sequencer for jtkcpu_idx: 3 cen cycles start-to-done, +1 per offset byte, PRE or POST, +3 indirect; a missing bus_ack holds state.
// Define JTKCPU_IDX_ILLEGAL_EN to add the `illegal` output for modes C-F; otherwise they decode as mode 0.
module jtkcpu_idx_seq (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        start,
    input  logic [7:0]  postbyte,
    input  logic [7:0]  din,
    input  logic        bus_ack,
    input  logic [15:0] idx_addr,
    output logic        fetch_pc,
    output logic        fetch_ea,
    output logic        ptr_ofs,
    output logic [15:0] mdata,
    output logic [2:0]  reg_sel,
    output logic [1:0]  acc_sel,
    output logic        idx_8,
    output logic        idx_16,
    output logic        idx_acc,
    output logic        idx_dp,
    output logic        idx_ld,
    output logic        data2addr,
    output logic        reg_wr,
    output logic [15:0] reg_wdata_dlt,
    output logic        busy,
    output logic        done
`ifdef JTKCPU_IDX_ILLEGAL_EN
    ,
    output logic        illegal
`endif
);

    typedef enum logic [3:0] {
        IDLE, PRE, OF1, OF2, CALC, POST, IH, IL, ILD, DONE
    } state_t;

    state_t     st;
    logic [7:0] pb;

    // The pointer address is formed outside from idx_addr and ptr_ofs.
    logic unused_idx_addr;
    assign unused_idx_addr = ^idx_addr;

    function automatic logic is_pc(input logic [7:0] p);
        return p[6:4] == 3'd4;
    endfunction

    function automatic logic [2:0] map_reg(input logic [2:0] r);
        return (r > 3'd4) ? 3'd0 : r;
    endfunction

    function automatic logic need_pre(input logic [7:0] p);
        return (p[3:0] == 4'h8 || p[3:0] == 4'h9) && !is_pc(p);
    endfunction

    function automatic logic need_post(input logic [7:0] p);
        return (p[3:0] == 4'h6 || p[3:0] == 4'h7) && !is_pc(p);
    endfunction

    function automatic logic need_ofs(input logic [7:0] p);
        return p[3:0] == 4'h1 || p[3:0] == 4'h2 || p[3:0] == 4'hA || p[3:0] == 4'hB;
    endfunction

    // {idx_ld, idx_8, idx_16, idx_acc, idx_dp, data2addr, acc_sel}
    function automatic logic [7:0] calc_out(input logic [7:0] p);
        case (p[3:0])
            4'h1:    return 8'b010000_00;
            4'h2:    return 8'b001000_00;
            4'h3:    return 8'b000100_00;
            4'h4:    return 8'b000100_01;
            4'h5:    return 8'b000100_10;
            4'hA:    return 8'b000001_00;
            4'hB:    return 8'b000010_00;
            default: return 8'b100000_00;
        endcase
    endfunction

`ifdef JTKCPU_IDX_ILLEGAL_EN
    assign illegal = done & (pb[3:2] == 2'b11);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st            <= IDLE;
            pb            <= 8'h00;
            fetch_pc      <= 1'b0;
            fetch_ea      <= 1'b0;
            ptr_ofs       <= 1'b0;
            mdata         <= 16'h0000;
            reg_sel       <= 3'd0;
            acc_sel       <= 2'd0;
            idx_8         <= 1'b0;
            idx_16        <= 1'b0;
            idx_acc       <= 1'b0;
            idx_dp        <= 1'b0;
            idx_ld        <= 1'b0;
            data2addr     <= 1'b0;
            reg_wr        <= 1'b0;
            reg_wdata_dlt <= 16'h0000;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else if (cen) begin
            {idx_ld, idx_8, idx_16, idx_acc, idx_dp, data2addr} <= 6'b000000;
            reg_wr <= 1'b0;
            done   <= 1'b0;
            case (st)
                IDLE: if (start) begin
                    pb      <= postbyte;
                    busy    <= 1'b1;
                    reg_sel <= map_reg(postbyte[6:4]);
                    if (need_pre(postbyte)) begin
                        st            <= PRE;
                        reg_wr        <= 1'b1;
                        reg_wdata_dlt <= postbyte[0] ? 16'hFFFE : 16'hFFFF;
                    end else if (need_ofs(postbyte)) begin
                        st       <= OF1;
                        fetch_pc <= 1'b1;
                    end else begin
                        st <= CALC;
                        {idx_ld, idx_8, idx_16, idx_acc, idx_dp, data2addr, acc_sel} <= calc_out(postbyte);
                    end
                end
                PRE: begin
                    st <= CALC;
                    {idx_ld, idx_8, idx_16, idx_acc, idx_dp, data2addr, acc_sel} <= calc_out(pb);
                end
                OF1: if (bus_ack) begin
                    if (pb[3:0] == 4'h1 || pb[3:0] == 4'hB) begin
                        mdata    <= {8'h00, din};
                        fetch_pc <= 1'b0;
                        st       <= CALC;
                        {idx_ld, idx_8, idx_16, idx_acc, idx_dp, data2addr, acc_sel} <= calc_out(pb);
                    end else begin
                        // fetch_pc stays up straight into the low byte
                        mdata[15:8] <= din;
                        st          <= OF2;
                    end
                end
                OF2: if (bus_ack) begin
                    mdata[7:0] <= din;
                    fetch_pc   <= 1'b0;
                    st         <= CALC;
                    {idx_ld, idx_8, idx_16, idx_acc, idx_dp, data2addr, acc_sel} <= calc_out(pb);
                end
                CALC: begin
                    if (need_post(pb)) begin
                        st            <= POST;
                        reg_wr        <= 1'b1;
                        reg_wdata_dlt <= pb[0] ? 16'h0002 : 16'h0001;
                    end else if (pb[7]) begin
                        st       <= IH;
                        fetch_ea <= 1'b1;
                        ptr_ofs  <= 1'b0;
                    end else begin
                        st   <= DONE;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                POST: begin
                    if (pb[7]) begin
                        st       <= IH;
                        fetch_ea <= 1'b1;
                        ptr_ofs  <= 1'b0;
                    end else begin
                        st   <= DONE;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                IH: if (bus_ack) begin
                    mdata[15:8] <= din;
                    ptr_ofs     <= 1'b1;
                    st          <= IL;
                end
                IL: if (bus_ack) begin
                    mdata[7:0] <= din;
                    fetch_ea   <= 1'b0;
                    ptr_ofs    <= 1'b0;
                    data2addr  <= 1'b1;
                    st         <= ILD;
                end
                ILD: begin
                    st   <= DONE;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                DONE:    st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

endmodule
